// File: rtl/countdown_secs_timer.sv
// Seconds countdown timer feeding the SSD digit decoder; prescales clk to a 1 s tick.
// Latency: every output is registered and reflects the controls sampled on the same posedge.
// Backpressure: none; the control inputs are level-sampled every cycle and never stalled.
module countdown_secs_timer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int MAX_SECS      = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [5:0] secs,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       tick
);

    // A single-cycle "second" still needs at least one prescaler bit to stay legal.
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    MAX_VAL    = 6'(MAX_SECS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [5:0]    r_secs;
    logic [5:0]    w_secs_nxt;
    logic          r_running;
    logic          r_done;
    logic          r_expired;
    logic          r_tick;
    logic          w_tick_nxt;
    logic          w_expired_nxt;
    logic [5:0]    w_load_clamped;

    assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Next-state and next-output decode; clear beats every other control in any state.
    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_secs_nxt    = r_secs;
        w_tick_nxt    = 1'b0;
        w_expired_nxt = 1'b0;

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_secs_nxt  = 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        w_secs_nxt  = w_load_clamped;
                        w_presc_nxt = '0;
                    end else if (start && (r_secs != 6'd0)) begin
                        w_state_nxt = S_RUN;
                        w_presc_nxt = '0;
                    end
                end
                S_PAUSE: begin
                    if (load) begin
                        w_state_nxt = S_IDLE;
                        w_secs_nxt  = w_load_clamped;
                        w_presc_nxt = '0;
                    end else if (start) begin
                        // Resume keeps the partially elapsed second.
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    if (load) begin
                        w_state_nxt = S_IDLE;
                        w_secs_nxt  = w_load_clamped;
                        w_presc_nxt = '0;
                    end
                end
                S_RUN: begin
                    // The prescaler advances on the pause cycle too, so a pause on the
                    // terminal count still produces its decrement and tick.
                    if (r_presc == PRESC_LAST) begin
                        w_presc_nxt = '0;
                        w_tick_nxt  = 1'b1;
                        if (r_secs <= 6'd1) begin
                            w_secs_nxt    = 6'd0;
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end else begin
                            w_secs_nxt = r_secs - 6'd1;
                            if (pause) begin
                                w_state_nxt = S_PAUSE;
                            end
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                        if (pause) begin
                            w_state_nxt = S_PAUSE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and status flags all register together so outputs stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_secs    <= 6'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_secs    <= w_secs_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
            r_expired <= w_expired_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign secs    = r_secs;
    assign running = r_running;
    assign done    = r_done;
    assign expired = r_expired;
    assign tick    = r_tick;

endmodule

// File: tb/tb_countdown_secs_timer.sv
// Directed bench for countdown_secs_timer with a 4-cycle second and MAX_SECS of 59.
// Inputs change 1 ns after a posedge; outputs are checked at that same point.
// Each step advances exactly one clock edge, so expected values are edge counts.
module tb_countdown_secs_timer;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       load;
    logic [5:0] load_val;
    logic       start;
    logic       pause;
    logic [5:0] secs;
    logic       running;
    logic       done;
    logic       expired;
    logic       tick;

    int checks = 0;
    int errors = 0;

    countdown_secs_timer #(
        .TICKS_PER_SEC(4),
        .MAX_SECS     (59)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .load    (load),
        .load_val(load_val),
        .start   (start),
        .pause   (pause),
        .secs    (secs),
        .running (running),
        .done    (done),
        .expired (expired),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge and settle 1 ns past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_secs, input int e_run,
                           input int e_done, input int e_exp, input int e_tick);
        chk({tag, ".secs"},    int'(secs),    e_secs);
        chk({tag, ".running"}, int'(running), e_run);
        chk({tag, ".done"},    int'(done),    e_done);
        chk({tag, ".expired"}, int'(expired), e_exp);
        chk({tag, ".tick"},    int'(tick),    e_tick);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 6'd0;
        start = 1'b0; pause = 1'b0;
        cyc(); cyc();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Basic countdown of 3: decrements land on edges 4, 8, 12 after start.
        load = 1'b1; load_val = 6'd3; cyc(); load = 1'b0;
        chk_all("t1_load", 3, 0, 0, 0, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t1_start", 3, 1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk_all($sformatf("t1_e%0d", k), 3 - (k / 4), (k < 12) ? 1 : 0,
                    (k == 12) ? 1 : 0, (k == 12) ? 1 : 0, (k % 4 == 0) ? 1 : 0);
        end
        cyc();
        chk_all("t1_done_hold1", 0, 0, 1, 0, 0);
        cyc();
        chk_all("t1_done_hold2", 0, 0, 1, 0, 0);

        // Load above MAX clamps; start with zero after clear is ignored.
        load = 1'b1; load_val = 6'd63; cyc(); load = 1'b0;
        chk_all("t2_clamp", 59, 0, 0, 0, 0);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk_all("t2_clear", 0, 0, 0, 0, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t2_start_zero", 0, 0, 0, 0, 0);
        cyc();
        chk_all("t2_still_idle", 0, 0, 0, 0, 0);

        // Pause on edge 2 (prescaler reaches 2), hold 10, resume: decrement 2 edges later.
        load = 1'b1; load_val = 6'd5; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        pause = 1'b1; cyc(); pause = 1'b0;
        chk_all("t3_paused", 5, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("t3_hold%0d.secs", k), int'(secs), 5);
            chk($sformatf("t3_hold%0d.running", k), int'(running), 0);
        end
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("t3_resume", 5, 1, 0, 0, 0);
        cyc();
        chk_all("t3_resume_p1", 5, 1, 0, 0, 0);
        cyc();
        chk_all("t3_resume_p2", 4, 1, 0, 0, 1);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk_all("t3_clear", 0, 0, 0, 0, 0);

        // Pause on the terminal count of the last second: DONE wins.
        load = 1'b1; load_val = 6'd1; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        chk_all("t4_pre", 1, 1, 0, 0, 0);
        pause = 1'b1; cyc(); pause = 1'b0;
        chk_all("t4_term_pause", 0, 0, 1, 1, 1);
        cyc();
        chk_all("t4_after", 0, 0, 1, 0, 0);

        // Load from DONE, then load ignored in RUN, then clear beats load.
        load = 1'b1; load_val = 6'd5; cyc(); load = 1'b0;
        chk_all("t5_load_from_done", 5, 0, 0, 0, 0);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk_all("t5_at4", 4, 1, 0, 0, 1);
        load = 1'b1; load_val = 6'd9; cyc(); load = 1'b0;
        chk_all("t5_load_ignored", 4, 1, 0, 0, 0);
        cyc(); cyc(); cyc();
        chk_all("t5_continues", 3, 1, 0, 0, 1);
        clear = 1'b1; load = 1'b1; load_val = 6'd9; cyc();
        clear = 1'b0; load = 1'b0;
        chk_all("t5_clear_over_load", 0, 0, 0, 0, 0);

        // Reset mid-count, then a fresh countdown of 2.
        load = 1'b1; load_val = 6'd3; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk_all("t6_at2", 2, 1, 0, 0, 1);
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk_all("t6_reset", 0, 0, 0, 0, 0);
        load = 1'b1; load_val = 6'd2; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        chk_all("t6_e3", 2, 1, 0, 0, 0);
        cyc();
        chk_all("t6_e4", 1, 1, 0, 0, 1);
        cyc(); cyc(); cyc(); cyc();
        chk_all("t6_e8", 0, 0, 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_secs_timer.md
Name: countdown_secs_timer

Overview:
- Seconds countdown timer that produces the 6-bit `secs` value consumed by the SSD digit decoder, which renders it as two seven-segment digits.
- Divides `clk` down to a 1 s tick and counts a loaded value down to 0.
- Supports start, pause/resume and clear control, and flags expiry.
- Sits between the user control/debounce logic and the SSD decoder.

Parameters:
- TICKS_PER_SEC, default 100000000: `clk` cycles per second; the bench uses 4.
- MAX_SECS, default 59: largest value `secs` may hold; loads above it clamp to it. Legal range 1..63.

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  reset, synchronous, active-high
- `clear`  input  1  abort and zero the timer
- `load`  input  1  load `load_val` (level sampled each cycle)
- `load_val`  input  6  seconds value to load
- `start`  input  1  start from IDLE or resume from PAUSE
- `pause`  input  1  pause while RUN
- `secs`  output  6  current seconds remaining, registered, to SSD decoder
- `running`  output  1  high while in RUN
- `done`  output  1  high while in DONE
- `expired`  output  1  one-cycle pulse on entry to DONE
- `tick`  output  1  one-cycle pulse on each 1 s decrement

Behaviour:
- All state and outputs are registered and updated on `posedge clk`; there are no combinational input-to-output paths.
- Reset (`rst`=1): state=IDLE, `secs`=0, prescaler=0, and `running`, `done`, `expired`, `tick` all 0. `rst` overrides every other input.
- Prescaler width is `clog2(TICKS_PER_SEC)`. It counts only in RUN, from 0 to TICKS_PER_SEC-1, then wraps to 0.
- Control priority per cycle: `rst` > `clear` > `load` > `start` > `pause`. Only the highest-priority applicable control acts.
- States: IDLE, RUN, PAUSE, DONE.
- `clear` (any state): go to IDLE, `secs`=0, prescaler=0. No `expired` pulse.
- `load` in IDLE, PAUSE or DONE:
  - `secs` = min(`load_val`, MAX_SECS), prescaler=0, go to IDLE.
  - `load` is ignored in RUN.
- `start`:
  - In IDLE with `secs`>0: go to RUN with prescaler=0. The first decrement occurs exactly TICKS_PER_SEC cycles after the `start` edge.
  - In IDLE with `secs`=0: ignored.
  - In PAUSE: go to RUN, prescaler resumes from its held value.
  - In RUN or DONE: ignored.
- RUN, when prescaler = TICKS_PER_SEC-1:
  - prescaler wraps to 0, `secs` decrements by 1, and `tick`=1 for that one cycle (aligned with the new `secs` value).
  - If the new `secs` is 0: go to DONE, and `expired`=1 in the same cycle that `secs` first reads 0.
- `pause` in RUN: go to PAUSE; prescaler and `secs` hold. `pause` is ignored in other states.
- `pause` coinciding with a terminal prescaler count: the decrement and `tick` still occur that cycle.
  - Next state is PAUSE.
  - If `secs` reached 0, DONE wins over PAUSE and `expired` pulses.
- DONE: `secs` holds 0 and `done`=1. Exit only via `load` or `clear`, both to IDLE.
- `running` = (state==RUN) and `done` = (state==DONE), both registered with the state.
- `expired` and `tick` are each exactly one cycle wide; neither repeats while the timer stays in DONE.
- `secs` never exceeds MAX_SECS and never underflows below 0.
- Reset mid-count: the next cycle shows IDLE, `secs`=0, no `tick` and no `expired`.

Test Plan:
- Reset, then load `load_val`=3, start (TICKS_PER_SEC=4) -> `secs` goes 3→2→1→0 at cycles 4, 8, 12 after `start`. `tick` pulses at each decrement; `expired` is a single pulse with `secs`=0 at cycle 12; `done`=1 thereafter.
- Load 63 with MAX_SECS=59 -> `secs`=59 in IDLE. Start with `secs`=0 after `clear` -> remains IDLE, `running`=0.
- Load 5, start, pause 2 cycles after `start` and hold 10 cycles, then start again -> `secs` stays 5 while paused. First decrement to 4 arrives 2 cycles after resume (prescaler resumed at 2).
- Load 1, start, assert `pause` exactly on the terminal prescaler cycle -> `secs`=0, state DONE, `expired`=1 once, `running`=0.
- In RUN at `secs`=4, assert `load`=1 with `load_val`=9 -> ignored, countdown continues. Assert `clear` and `load` together -> `secs`=0, IDLE.
- Assert `rst` while `secs`=2 mid-count -> `secs`=0 and all outputs 0 on the next edge. Load 2 and start -> normal countdown with the first tick after 4 cycles.
